// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces one quotient bit per cycle. Result is {remainder, quotient}:
// the upper half goes to HI and the lower half goes to LO.
//
// Parameters
//   WIDTH  operand width in bits (>= 4); the result bus is 2*WIDTH
//   CNT_W  width of the iteration counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   signed_i   1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i  dividend
//   opdata2_i  divisor
//   start_i    request, held high by EX until ready_o is seen
//   annul_i    abort the division in flight (pipeline flush)
//   result_o   {remainder, quotient}
//   ready_o    result valid
//   busy_o     unit is in a state other than FREE (registered)
//
// Optional feature (build macro DIV_FAST_ZERO_EN)
//   When defined, a zero dividend with a non-zero divisor takes the short
//   BY_ZERO path and returns 0 after two edges instead of WIDTH+2. The
//   result is 0 either way; only the latency changes.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {ST_FREE, ST_BY_ZERO, ST_ON, ST_END} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   dvd, dvd_n;   // dividend; quotient bits shift in at the bottom
  logic [WIDTH-1:0]   dvs, dvs_n;   // divisor magnitude
  logic [WIDTH-1:0]   rem, rem_n;   // partial remainder
  logic               neg_q, neg_q_n;
  logic               neg_r, neg_r_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;
  logic               busy_n;

  logic               req;
  logic               zero_path;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     rem_sh, trial;
  logic [WIDTH-1:0]   q_fin, r_fin;

  assign req  = start_i & ~annul_i;
  assign mag1 = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_FAST_ZERO_EN
  assign zero_path = (opdata2_i == '0) | (opdata1_i == '0);
`else
  assign zero_path = (opdata2_i == '0);
`endif

  // rem < dvs always holds, so the WIDTH+1-bit difference never overflows
  // and its MSB is a reliable sign.
  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs};
  assign q_fin  = neg_q ? -dvd : dvd;
  assign r_fin  = neg_r ? -rem : rem;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FREE;
    else      state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FREE:    if (req) state_nxt = zero_path ? ST_BY_ZERO : ST_ON;
      ST_BY_ZERO: state_nxt = ST_END;
      ST_ON: begin
        if (annul_i)                         state_nxt = ST_FREE;
        else if (cnt == CNT_W'(WIDTH))       state_nxt = ST_END;
      end
      ST_END:     if (!start_i) state_nxt = ST_FREE;
      default:    state_nxt = ST_FREE;
    endcase
  end

  // outputs and datapath next values
  always_comb begin
    cnt_n    = cnt;
    dvd_n    = dvd;
    dvs_n    = dvs;
    rem_n    = rem;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result_o;
    ready_n  = ready_o;
    busy_n   = (state_nxt != ST_FREE);
    case (state)
      ST_FREE: begin
        result_n = '0;
        ready_n  = 1'b0;
        if (req && !zero_path) begin
          dvd_n   = mag1;
          dvs_n   = mag2;
          rem_n   = '0;
          cnt_n   = '0;
          neg_q_n = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_r_n = signed_i & opdata1_i[WIDTH-1];
        end
      end
      ST_BY_ZERO: begin
        result_n = '0;
        ready_n  = 1'b1;
      end
      ST_ON: begin
        if (!annul_i) begin
          if (cnt != CNT_W'(WIDTH)) begin
            dvd_n = {dvd[WIDTH-2:0], ~trial[WIDTH]};
            rem_n = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt_n = cnt + CNT_W'(1);
          end else begin
            result_n = {r_fin, q_fin};
            ready_n  = 1'b1;
          end
        end
      end
      ST_END: begin
        if (!start_i) begin
          result_n = '0;
          ready_n  = 1'b0;
        end
      end
      default: begin
        result_n = '0;
        ready_n  = 1'b0;
      end
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      dvd      <= dvd_n;
      dvs      <= dvs_n;
      rem      <= rem_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      result_o <= result_n;
      ready_o  <= ready_n;
      busy_o   <= busy_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  localparam int W = 32;
`ifdef DIV_FAST_ZERO_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = W + 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_i = 1'b0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .signed_i(signed_i),
    .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  // Issue a request and count rising edges until ready_o (bounded).
  task automatic run_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int edges);
    @(negedge clk);
    signed_i = sg; op1 = a; op2 = b; start_i = 1'b1; annul_i = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ready_o && edges < 100);
  endtask

  task automatic drop_start();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", result_o); end
    n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_unsigned();
    int e;
    run_div(1'b0, 32'd7, 32'd2, e);
    n_vec++; if (e !== 34) begin n_err++; $display("FAIL udiv_latency got %0d want 34", e); end
    n_vec++; if (result_o !== {32'h1, 32'h3}) begin n_err++; $display("FAIL udiv_7_2 got %h want %h", result_o, {32'h1, 32'h3}); end
    drop_start();
    n_vec++; if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== '0) begin
      n_err++; $display("FAIL udiv_drop got rdy=%b busy=%b res=%h want 0/0/0", ready_o, busy_o, result_o); end
  endtask

  task automatic test_signed();
    int e;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, e);
    n_vec++; if (e !== 34) begin n_err++; $display("FAIL sdiv_latency got %0d want 34", e); end
    n_vec++; if (result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL sdiv_m7_2 got %h want %h", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    drop_start();
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, e);
    n_vec++; if (result_o !== {32'h0000_0001, 32'h7FFF_FFFC}) begin
      n_err++; $display("FAIL udiv_big_2 got %h want %h", result_o, {32'h0000_0001, 32'h7FFF_FFFC}); end
    drop_start();
    // positive dividend, negative divisor: 20 / -3 = -6 rem 2
    run_div(1'b1, 32'd20, 32'hFFFF_FFFD, e);
    n_vec++; if (result_o !== {32'h0000_0002, 32'hFFFF_FFFA}) begin
      n_err++; $display("FAIL sdiv_20_m3 got %h want %h", result_o, {32'h0000_0002, 32'hFFFF_FFFA}); end
    drop_start();
  endtask

  task automatic test_div_zero();
    int e;
    run_div(1'b0, 32'd5, 32'd0, e);
    n_vec++; if (e !== 2) begin n_err++; $display("FAIL dz_latency got %0d want 2", e); end
    n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL dz_result got %h want 0", result_o); end
    drop_start();
    n_vec++; if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL dz_drop got rdy=%b busy=%b want 0/0", ready_o, busy_o); end
    run_div(1'b1, 32'd5, 32'd0, e);
    n_vec++; if (e !== 2 || result_o !== '0) begin
      n_err++; $display("FAIL dz_signed got lat=%0d res=%h want 2/0", e, result_o); end
    drop_start();
  endtask

  task automatic test_annul();
    int e;
    @(negedge clk);
    signed_i = 1'b0; op1 = 32'd100; op2 = 32'd3; start_i = 1'b1; annul_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL annul_busy_before got %b want 1", busy_o); end
    @(negedge clk) annul_i = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      n_err++; $display("FAIL annul_abort got busy=%b rdy=%b want 0/0", busy_o, ready_o); end
    // annul held with start high in FREE must block acceptance
    repeat (3) begin
      @(posedge clk); #1;
      n_vec++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
        n_err++; $display("FAIL annul_free_block got busy=%b rdy=%b want 0/0", busy_o, ready_o); end
    end
    run_div(1'b0, 32'd100, 32'd3, e);
    n_vec++; if (e !== 34 || result_o !== {32'd1, 32'd33}) begin
      n_err++; $display("FAIL annul_restart got lat=%0d res=%h want 34/%h", e, result_o, {32'd1, 32'd33}); end
    drop_start();
  endtask

  task automatic test_overflow_hold();
    int e;
    @(negedge clk);
    signed_i = 1'b1; op1 = 32'h8000_0000; op2 = 32'hFFFF_FFFF; start_i = 1'b1; annul_i = 1'b0;
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
      // operands and mode are scrambled once the request is latched
      op1 = $urandom; op2 = $urandom; signed_i = ~signed_i;
    end while (!ready_o && e < 100);
    n_vec++; if (e !== 34) begin n_err++; $display("FAIL ovf_latency got %0d want 34", e); end
    n_vec++; if (result_o !== {32'h0, 32'h8000_0000}) begin
      n_err++; $display("FAIL ovf_result got %h want %h", result_o, {32'h0, 32'h8000_0000}); end
    annul_i = 1'b1; // no effect in END
    repeat (5) begin
      @(posedge clk); #1;
      n_vec++; if (ready_o !== 1'b1 || result_o !== {32'h0, 32'h8000_0000}) begin
        n_err++; $display("FAIL ovf_hold got rdy=%b res=%h want 1/%h", ready_o, result_o, {32'h0, 32'h8000_0000}); end
    end
    annul_i = 1'b0;
    drop_start();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    signed_i = 1'b0; op1 = 32'd100; op2 = 32'd3; start_i = 1'b1; annul_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL arst_busy_before got %b want 1", busy_o); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== '0) begin
      n_err++; $display("FAIL arst_outputs got busy=%b rdy=%b res=%h want 0/0/0", busy_o, ready_o, result_o); end
    start_i = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_fast_zero();
    int e;
    run_div(1'b0, 32'd0, 32'd9, e);
    n_vec++; if (e !== ZLAT) begin n_err++; $display("FAIL zero_latency got %0d want %0d", e, ZLAT); end
    n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL zero_result got %h want 0", result_o); end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_overflow_hold();
    test_async_reset();
    test_fast_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
